// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter.
// - Holds the grant through counted bursts (4/8/16 beats) and through locked sequences.
// - Parks the bus on DEFAULT_MGR when no manager is requesting.
// - All grant and owner state advances only on Hready=1 edges.
module ahb_arbiter #(
    parameter int unsigned NUM_MANAGERS = 3,
    parameter int unsigned DEFAULT_MGR  = 0,
    parameter int unsigned MW           = $clog2(NUM_MANAGERS)
) (
    input  logic                    Hclk,
    input  logic                    Hresetn,
    input  logic [NUM_MANAGERS-1:0] Hbusreq,
    input  logic [NUM_MANAGERS-1:0] Hlock,
    input  logic [1:0]              Htrans,
    input  logic [2:0]              Hburst,
    input  logic                    Hready,
    output logic [NUM_MANAGERS-1:0] Hgrant,
    output logic [MW-1:0]           Hmaster,
    output logic                    Hmastlock
);

    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [NUM_MANAGERS-1:0] DefGrant =
        {{(NUM_MANAGERS-1){1'b0}}, 1'b1} << DEFAULT_MGR;

    // Arbitration mode for the current edge: decides whether the grant may move.
    typedef enum logic [1:0] {
        StPark,
        StOwn,
        StBurst,
        StLocked
    } arb_state_e;

    logic [NUM_MANAGERS-1:0] grant_q, grant_d;
    logic [MW-1:0]           master_q, master_d;
    logic                    mastlock_q, mastlock_d;
    logic [3:0]              beats_q, beats_d;

    arb_state_e              arb_state;
    int unsigned             owner_idx;
    logic                    owner_lock;
    logic                    owner_req;
    logic [NUM_MANAGERS-1:0] hi_req;
    logic [NUM_MANAGERS-1:0] rr_grant;
    logic                    rr_found;

    // Decode the one-hot grant into an index and pick out the owner's request/lock bits.
    always_comb begin
        owner_idx = 0;
        for (int unsigned k = 0; k < NUM_MANAGERS; k++) begin
            if (grant_q[k]) begin
                owner_idx = k;
            end
        end
        owner_lock = |(Hlock & grant_q);
        owner_req  = |(Hbusreq & grant_q);
    end

    // Burst counter next value: load on NONSEQ, count down on SEQ, hold otherwise.
    always_comb begin
        beats_d = beats_q;
        if (Hready) begin
            case (Htrans)
                TransNonseq: begin
                    case (Hburst)
                        3'd2, 3'd3: beats_d = 4'd3;
                        3'd4, 3'd5: beats_d = 4'd7;
                        3'd6, 3'd7: beats_d = 4'd15;
                        default:    beats_d = 4'd0;
                    endcase
                end
                TransSeq: begin
                    if (beats_q != 4'd0) begin
                        beats_d = beats_q - 4'd1;
                    end
                end
                default: beats_d = beats_q;
            endcase
        end
    end

    // Circular scan starting after the owner: requesters above the owner win first,
    // then the lowest requester overall, so the owner itself is reached last.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        for (int unsigned k = 0; k < NUM_MANAGERS; k++) begin
            hi_req[k] = Hbusreq[k] && (k > owner_idx);
        end
        for (int unsigned k = 0; k < NUM_MANAGERS; k++) begin
            if (!rr_found && hi_req[k]) begin
                rr_grant[k] = 1'b1;
                rr_found    = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_MANAGERS; k++) begin
            if (!rr_found && Hbusreq[k]) begin
                rr_grant[k] = 1'b1;
                rr_found    = 1'b1;
            end
        end
    end

    // Mode and next grant/owner; lock hold outranks the burst count.
    always_comb begin
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;

        if (owner_lock && owner_req) begin
            arb_state = StLocked;
        end else if (beats_d >= 4'd2) begin
            arb_state = StBurst;
        end else if (|Hbusreq) begin
            arb_state = StOwn;
        end else begin
            arb_state = StPark;
        end

        if (Hready) begin
            master_d   = MW'(owner_idx);
            mastlock_d = owner_lock;
            case (arb_state)
                StOwn:   grant_d = rr_grant;
                StPark:  grant_d = DefGrant;
                default: grant_d = grant_q;
            endcase
        end
    end

    // Grant, owner and burst count registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            grant_q    <= DefGrant;
            master_q   <= MW'(DEFAULT_MGR);
            mastlock_q <= 1'b0;
            beats_q    <= 4'd0;
        end else begin
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            beats_q    <= beats_d;
        end
    end

    assign Hgrant    = grant_q;
    assign Hmaster   = master_q;
    assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Testbench for ahb_arbiter.
// - Directed scenarios, then randomized traffic.
// - Every cycle is compared against a behavioural round-robin model.
module tb_ahb_arbiter;

    localparam int N   = 3;
    localparam int DEF = 0;

    logic       Hclk = 1'b0;
    logic       Hresetn;
    logic [2:0] Hbusreq;
    logic [2:0] Hlock;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic       Hready;
    logic [2:0] Hgrant;
    logic [1:0] Hmaster;
    logic       Hmastlock;

    ahb_arbiter #(
        .NUM_MANAGERS(N),
        .DEFAULT_MGR (DEF)
    ) dut (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .Hbusreq  (Hbusreq),
        .Hlock    (Hlock),
        .Htrans   (Htrans),
        .Hburst   (Hburst),
        .Hready   (Hready),
        .Hgrant   (Hgrant),
        .Hmaster  (Hmaster),
        .Hmastlock(Hmastlock)
    );

    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: granted index, owning index, beats remaining, owner lock.
    int m_grant;
    int m_master;
    int m_beats;
    int m_lock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bit_of(input logic [2:0] v, input int i);
        return (((v >> i) & 3'b001) != 3'b000) ? 1 : 0;
    endfunction

    function automatic int burst_len(input logic [2:0] b);
        if (b < 3'd2) return 1;
        if (b < 3'd4) return 4;
        if (b < 3'd6) return 8;
        return 16;
    endfunction

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_beats  = 0;
        m_lock   = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int nb;
        int ng;
        int hold;
        int found;
        if (Hready) begin
            nb = m_beats;
            if (Htrans == 2'd2) nb = burst_len(Hburst) - 1;
            else if (Htrans == 2'd3 && nb > 0) nb = nb - 1;
            hold = (nb >= 2 || (bit_of(Hlock, m_grant) == 1 && bit_of(Hbusreq, m_grant) == 1))
                   ? 1 : 0;
            m_master = m_grant;
            m_lock   = bit_of(Hlock, m_grant);
            ng = m_grant;
            if (hold == 0) begin
                if (Hbusreq == 3'b000) begin
                    ng = DEF;
                end else begin
                    found = 0;
                    for (int i = 1; i <= N; i++) begin
                        if (found == 0 && bit_of(Hbusreq, (m_grant + i) % N) == 1) begin
                            ng    = (m_grant + i) % N;
                            found = 1;
                        end
                    end
                end
            end
            m_beats = nb;
            m_grant = ng;
        end
    endtask

    // One clock: update model, let the edge pass, compare outputs 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge Hclk);
        #1;
        check("grant", 32'(Hgrant), 32'(1 << m_grant));
        check("master", 32'(Hmaster), 32'(m_master));
        check("mastlock", 32'(Hmastlock), 32'(m_lock));
        check("onehot", 32'($onehot(Hgrant)), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rot[4];
        int edges;
        rot[0] = 3'b010;
        rot[1] = 3'b100;
        rot[2] = 3'b001;
        rot[3] = 3'b010;

        Hresetn = 1'b0;
        Hbusreq = '0;
        Hlock   = '0;
        Htrans  = 2'd0;
        Hburst  = 3'd0;
        Hready  = 1'b1;
        model_reset();
        repeat (2) @(posedge Hclk);
        #1;
        check("reset_grant", 32'(Hgrant), 1);
        check("reset_master", 32'(Hmaster), 0);
        check("reset_mastlock", 32'(Hmastlock), 0);
        Hresetn = 1'b1;

        // Round-robin rotation with SINGLE transfers.
        Hbusreq = 3'b111;
        Htrans  = 2'd2;
        Hburst  = 3'd0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rotation", 32'(Hgrant), 32'(rot[k]));
        end
        cycle();
        check("pre_reset_grant", 32'(Hgrant), 32'(3'b100));

        // Asynchronous reset mid-cycle, away from any clock edge.
        #1;
        Hresetn = 1'b0;
        #1;
        check("async_reset_grant", 32'(Hgrant), 1);
        check("async_reset_master", 32'(Hmaster), 0);
        check("async_reset_mastlock", 32'(Hmastlock), 0);
        model_reset();
        Hbusreq = '0;
        Htrans  = 2'd0;
        @(posedge Hclk);
        #1;
        check("in_reset_grant", 32'(Hgrant), 1);
        Hresetn = 1'b1;
        cycle();
        cycle();
        check("post_reset_grant", 32'(Hgrant), 1);

        // Burst hold: manager 1 owns the bus and issues INCR4 while manager 0 requests.
        Hbusreq = 3'b010;
        cycle();
        cycle();
        check("burst_owner", 32'(Hmaster), 1);
        Hbusreq = 3'b011;
        Htrans  = 2'd2;
        Hburst  = 3'd3;
        cycle();
        check("burst_beat1", 32'(Hgrant), 32'(3'b010));
        Htrans = 2'd3;
        cycle();
        check("burst_beat2", 32'(Hgrant), 32'(3'b010));
        cycle();
        check("burst_beat3", 32'(Hgrant), 32'(3'b001));
        check("burst_beat3_master", 32'(Hmaster), 1);
        cycle();
        check("burst_beat4_master", 32'(Hmaster), 0);

        // Lock hold by manager 2 against full contention.
        Hbusreq = 3'b111;
        Hlock   = 3'b100;
        Htrans  = 2'd2;
        Hburst  = 3'd0;
        for (int k = 0; k < 8 && m_grant != 2; k++) cycle();
        check("lock_acquire", 32'(Hgrant), 32'(3'b100));
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("lock_hold", 32'(Hgrant), 32'(3'b100));
            check("lock_mastlock", 32'(Hmastlock), 1);
        end
        Hlock = 3'b000;
        cycle();
        check("lock_release", 32'(Hgrant), 32'(3'b001));

        // Wait states in the middle of an INCR8 owned by manager 0.
        Hbusreq = 3'b001;
        Htrans  = 2'd0;
        for (int k = 0; k < 8 && !(m_grant == 0 && m_master == 0); k++) cycle();
        check("wait_setup", 32'(Hmaster), 0);
        Hbusreq = 3'b011;
        Htrans  = 2'd2;
        Hburst  = 3'd5;
        cycle();
        Htrans = 2'd3;
        cycle();
        cycle();
        Hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("wait_grant", 32'(Hgrant), 32'(3'b001));
            check("wait_master", 32'(Hmaster), 0);
        end
        Hready = 1'b1;
        edges  = 5;
        for (int k = 0; k < 20 && Hgrant == 3'b001; k++) begin
            cycle();
            edges++;
        end
        check("wait_handover_edges", 32'(edges), 9);
        Htrans = 2'd0;

        // Parking on the default manager after manager 2 releases.
        Hbusreq = 3'b100;
        for (int k = 0; k < 8 && m_master != 2; k++) cycle();
        check("park_setup", 32'(Hmaster), 2);
        Hbusreq = 3'b000;
        cycle();
        check("park_grant", 32'(Hgrant), 32'(3'b001));
        cycle();
        check("park_master", 32'(Hmaster), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            Hbusreq = 3'($urandom);
            Hlock   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            Htrans  = 2'($urandom);
            Hburst  = 3'($urandom);
            Hready  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
